// File: rtl/ccl_frame_sequencer.sv
// ccl_frame_sequencer: raster scan, pipeline flush and per-object report for the CCL labeller.
// Revision: 1.0
`default_nettype none

module ccl_frame_sequencer #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int LOC_SIZE     = 11,
  parameter int WORD_SIZE    = 8,
  parameter int FLUSH_CYCLES = 3,
  parameter int READ_LAT     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LOC_SIZE-1:0]  min_area,
  input  logic                 pix_valid,
  input  logic                 pix_in,
  output logic                 ccl_en,
  output logic                 ccl_p,
  output logic [LOC_SIZE-1:0]  ccl_x,
  output logic [LOC_SIZE-1:0]  ccl_y,
  output logic [WORD_SIZE-1:0] ccl_obj_id,
  input  logic [WORD_SIZE-1:0] ccl_num_labels,
  input  logic [LOC_SIZE-1:0]  ccl_obj_area,
  input  logic [LOC_SIZE-1:0]  ccl_obj_x,
  input  logic [LOC_SIZE-1:0]  ccl_obj_y,
  output logic                 obj_valid,
  input  logic                 obj_ready,
  output logic [WORD_SIZE-1:0] obj_label,
  output logic [LOC_SIZE-1:0]  obj_area,
  output logic [LOC_SIZE-1:0]  obj_xsum,
  output logic [LOC_SIZE-1:0]  obj_ysum,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    FLUSH   = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    PRESENT = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam int CNT_MAX = (FLUSH_CYCLES > READ_LAT) ? FLUSH_CYCLES : READ_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [LOC_SIZE-1:0]  X_LAST     = LOC_SIZE'(WIDTH - 1);
  localparam logic [LOC_SIZE-1:0]  Y_LAST     = LOC_SIZE'(HEIGHT - 1);
  localparam logic [CNT_W-1:0]     FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]     WAIT_LAST  = CNT_W'(READ_LAT - 1);
  localparam logic [WORD_SIZE-1:0] ID_MAX     = {WORD_SIZE{1'b1}};

  state_t               state;
  logic [LOC_SIZE-1:0]  min_area_lat;
  logic [CNT_W-1:0]     cnt;
  logic [WORD_SIZE-1:0] next_id;

  // The object address saturates instead of wrapping back onto label 0.
  assign next_id = (ccl_obj_id == ID_MAX) ? ccl_obj_id : ccl_obj_id + WORD_SIZE'(1);

  assign busy   = (state != IDLE);
  assign ccl_en = ((state == SCAN) && pix_valid) || (state == FLUSH);
  assign ccl_p  = (state == SCAN) && pix_valid && pix_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      min_area_lat <= '0;
      cnt          <= '0;
      ccl_x        <= '0;
      ccl_y        <= '0;
      ccl_obj_id   <= '0;
      obj_valid    <= 1'b0;
      obj_label    <= '0;
      obj_area     <= '0;
      obj_xsum     <= '0;
      obj_ysum     <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= SCAN;
            min_area_lat <= min_area;
            ccl_x        <= '0;
            ccl_y        <= '0;
          end
        end

        SCAN: begin
          if (pix_valid) begin
            if (ccl_x == X_LAST) begin
              // The last pixel leaves the coordinates parked on the final position.
              if (ccl_y == Y_LAST) begin
                state <= FLUSH;
                cnt   <= '0;
              end else begin
                ccl_x <= '0;
                ccl_y <= ccl_y + LOC_SIZE'(1);
              end
            end else begin
              ccl_x <= ccl_x + LOC_SIZE'(1);
            end
          end
        end

        FLUSH: begin
          if (cnt == FLUSH_LAST) begin
            state      <= RD_ADDR;
            ccl_obj_id <= WORD_SIZE'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RD_ADDR: begin
          // Label 0 is background, so num_labels == 1 means there is nothing to report.
          if (ccl_obj_id >= ccl_num_labels) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else begin
            state <= RD_WAIT;
            cnt   <= '0;
          end
        end

        RD_WAIT: begin
          if (cnt == WAIT_LAST) begin
            obj_label <= ccl_obj_id;
            obj_area  <= ccl_obj_area;
            obj_xsum  <= ccl_obj_x;
            obj_ysum  <= ccl_obj_y;
            if (ccl_obj_area >= min_area_lat) begin
              state     <= PRESENT;
              obj_valid <= 1'b1;
            end else begin
              state      <= RD_ADDR;
              ccl_obj_id <= next_id;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        PRESENT: begin
          if (obj_ready) begin
            obj_valid  <= 1'b0;
            ccl_obj_id <= next_id;
            state      <= RD_ADDR;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/ccl_frame_sequencer.md
Name: ccl_frame_sequencer

Overview:
- Frame-level controller for the connected-components labelling datapath.
- During a frame it generates the raster coordinates, the pipeline enable and the pixel gating for the labeller. After the last pixel it flushes the labeller pipeline.
- It then walks the label range, reading each object's accumulated area/x-sum/y-sum through the labeller's object-read port. Objects at or above a minimum area go out as a valid/ready stream to the downstream object consumer.

Parameters:
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- LOC_SIZE, 11, coordinate and accumulator width; must hold max(WIDTH, HEIGHT) - 1.
- WORD_SIZE, 8, label width.
- FLUSH_CYCLES, 3, labeller pipeline depth to drain after the last pixel.
- READ_LAT, 1, cycles from obj_id change to valid obj_area/obj_x/obj_y.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  arm for one frame; sampled only in IDLE.
- min_area  in  LOC_SIZE  report threshold, latched on start.
- pix_valid  in  1  upstream pixel strobe.
- pix_in  in  1  binary pixel.
- ccl_en  out  1  enable to labeller.
- ccl_p  out  1  gated pixel to labeller.
- ccl_x  out  LOC_SIZE  current column.
- ccl_y  out  LOC_SIZE  current line.
- ccl_obj_id  out  WORD_SIZE  object read address.
- ccl_num_labels  in  WORD_SIZE  label counter from labeller.
- ccl_obj_area  in  LOC_SIZE  area read data.
- ccl_obj_x  in  LOC_SIZE  x-sum read data.
- ccl_obj_y  in  LOC_SIZE  y-sum read data.
- obj_valid  out  1  object stream valid.
- obj_ready  in  1  object stream ready.
- obj_label  out  WORD_SIZE  reported label.
- obj_area  out  LOC_SIZE  reported area.
- obj_xsum  out  LOC_SIZE  reported x-sum.
- obj_ysum  out  LOC_SIZE  reported y-sum.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at end of report.

Behaviour:
- Reset values: all outputs 0, state IDLE, x = y = 0, ccl_obj_id = 0.
- States: IDLE, SCAN, FLUSH, RD_ADDR, RD_WAIT, PRESENT, DONE.
- IDLE -> SCAN when start = 1. Latch min_area; clear x and y.
- SCAN:
  - ccl_en = pix_valid; ccl_p = pix_in & pix_valid.
  - Coordinates advance only on pix_valid. x wraps at WIDTH-1 to 0, and y increments on that wrap.
  - pix_valid at (WIDTH-1, HEIGHT-1) -> FLUSH. x and y hold at their final values, with no further wrap.
- FLUSH:
  - ccl_en = 1 and ccl_p = 0 for exactly FLUSH_CYCLES cycles; pix_valid is ignored.
  - Then go to RD_ADDR with ccl_obj_id = 1.
- ccl_en is 0 in every state other than SCAN and FLUSH.
- RD_ADDR:
  - If ccl_obj_id >= ccl_num_labels, go to DONE; this covers zero objects, where num_labels = 1.
  - Otherwise go to RD_WAIT.
- RD_WAIT:
  - Hold for READ_LAT cycles.
  - Capture ccl_obj_area/x/y into the obj_* registers and set obj_label = ccl_obj_id.
  - If captured area >= latched min_area, go to PRESENT.
  - Otherwise increment ccl_obj_id and go to RD_ADDR.
- PRESENT:
  - obj_valid = 1; all obj_* outputs are stable while valid and not ready.
  - On obj_valid & obj_ready: deassert valid the next cycle, increment ccl_obj_id, go to RD_ADDR.
  - One object per handshake, with a minimum 2 + READ_LAT cycles between consecutive valids.
- Label wrap: ccl_obj_id increments never wrap. If ccl_num_labels = 2^WORD_SIZE - 1 (saturated), the report ends after label 2^WORD_SIZE - 2.
- DONE: frame_done = 1 for one cycle, then IDLE. A start in the same cycle as DONE is ignored.
- busy is combinational from state.
- start while busy is ignored.
- reset in any state, including mid-handshake, returns to IDLE in the next cycle:
  - obj_valid drops without a handshake.
  - ccl_en = 0.
  - The in-flight frame is abandoned, with no frame_done.
- Arithmetic:
  - All coordinate compares are unsigned.
  - Area compare is unsigned, full LOC_SIZE width.
  - min_area = 0 reports every label.

Test Plan:
- WIDTH=4, HEIGHT=2, start, 8 pix_valid pulses with gaps -> ccl_x/y sequence (0,0)…(3,0),(0,1)…(3,1); ccl_en tracks pix_valid; state enters FLUSH with ccl_en=1, ccl_p=0 for exactly 3 cycles.
- ccl_num_labels=1 after flush -> no obj_valid; frame_done pulses 1 cycle after RD_ADDR; busy falls the following cycle.
- ccl_num_labels=4, modelled areas {5,1,7}, min_area=2 -> objects label 1 (area 5) and label 3 (area 7) only; label 2 is skipped silently.
- Same as the previous scenario with obj_ready held low 10 cycles -> obj_valid and all obj_* stable for 10 cycles; ccl_obj_id unchanged until handshake.
- reset asserted while obj_valid=1 -> next cycle obj_valid=0, busy=0, ccl_en=0, no frame_done; a new start runs a full frame correctly.
- start pulsed during SCAN and in the DONE cycle -> ignored; exactly one frame_done per accepted start.
